// File: rtl/debounce_timer_scheduler.sv
// Shared-prescaler debounce timers plus edge detection and round-robin event merge.
// Optional overwrite-status flags (evt_ovf/ovf_clear) are built when DBNC_OVF_STATUS_EN is defined.
module debounce_timer_scheduler #(
    parameter int N             = 4,
    parameter int TICK_DIV      = 100000,
    parameter int CNT_W         = 8,
    parameter int TICKS_DEFAULT = 10,
    localparam int CHW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     timer_reset,
    output logic [N-1:0]     timer_done,
    input  logic [N-1:0]     debounced,
    input  logic [CNT_W-1:0] cfg_ticks,
    input  logic             cfg_load,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CHW-1:0]   evt_chan,
    output logic             evt_press
`ifdef DBNC_OVF_STATUS_EN
    ,
    output logic [N-1:0]     evt_ovf,
    input  logic [N-1:0]     ovf_clear
`endif
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]    presc;
    logic             tick;
    logic [CNT_W-1:0] ticks_reg;
    logic [CNT_W-1:0] cnt [N];
    logic [N-1:0]     dbn_q;
    logic [N-1:0]     pending;
    logic [N-1:0]     lvl;
    logic [N-1:0]     edge_det;
    logic [CHW-1:0]   rr;
    logic [CHW-1:0]   sel;
    logic             sel_found;
    logic             load_ok;
    logic             grant;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= '0;
            ticks_reg <= CNT_W'(TICKS_DEFAULT);
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (cfg_load)
                ticks_reg <= (cfg_ticks == '0) ? CNT_W'(1) : cfg_ticks;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++)
                cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (timer_reset[i])
                    cnt[i] <= '0;
                else if (tick && (cnt[i] < ticks_reg))
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        timer_done = '0;
        for (int unsigned i = 0; i < N; i++)
            timer_done[i] = (cnt[i] >= ticks_reg) && !timer_reset[i];
    end

    assign edge_det = dbn_q ^ debounced;

    // Round-robin search starts just after the last granted channel.
    always_comb begin
        sel       = rr;
        sel_found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!sel_found && pending[(32'(rr) + k) % N]) begin
                sel       = CHW'((32'(rr) + k) % N);
                sel_found = 1'b1;
            end
        end
    end

    assign load_ok = !evt_valid || evt_ready;
    assign grant   = load_ok && sel_found;

    // A same-cycle edge on the granted channel wins over its clear, so the new level stays queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbn_q   <= '0;
            pending <= '0;
            lvl     <= '0;
        end else begin
            dbn_q <= debounced;
            for (int unsigned i = 0; i < N; i++) begin
                if (edge_det[i]) begin
                    pending[i] <= 1'b1;
                    lvl[i]     <= debounced[i];
                end else if (grant && (sel == CHW'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_chan  <= '0;
            evt_press <= 1'b0;
            rr        <= '0;
        end else if (load_ok) begin
            evt_valid <= sel_found;
            if (sel_found) begin
                evt_chan  <= sel;
                evt_press <= lvl[sel];
                rr        <= sel;
            end
        end
    end

`ifdef DBNC_OVF_STATUS_EN
    // An edge on a channel being granted this cycle loses nothing, so it is not an overwrite.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_ovf <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (edge_det[i] && pending[i] && !(grant && (sel == CHW'(i))))
                    evt_ovf[i] <= 1'b1;
                else if (ovf_clear[i])
                    evt_ovf[i] <= 1'b0;
            end
        end
    end
`endif

endmodule
